// File: rtl/intctl.sv
// rtl/intctl.sv - interrupt controller: pending latch, mask, vector acceptance, return holdoff
// Build option INTCTL_EDGE_EN: defined = edge-triggered event capture, undefined = level capture.
module intctl #(
    parameter int NUM_SRC = 4,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irqIn,
    input  logic               maskWe,
    input  logic [NUM_SRC-1:0] maskWd,
    input  logic               illOp,
    input  logic               pcEn,
    input  logic [WIDTH-1:0]   pcIn,
    input  logic               rfe,
    output logic               irq,
    output logic               iaBit,
    output logic [WIDTH-1:0]   epc,
    output logic [CW-1:0]      cause,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [CW-1:0]      sel;
    logic [NUM_SRC-1:0] clr_vec;
    logic               accept;

    assign irq    = |(pending & mask);
    assign iaBit  = (state == SERVICE) || (state == HOLDOFF);
    assign accept = (state == IDLE) && irq && !illOp && pcEn;

    // Priority select: lowest-index enabled pending source wins
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) begin
                sel = CW'(i);
            end
        end
    end

    // One-hot clear of the source being vectored this edge
    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[sel] = 1'b1;
        end
    end

    // Software mask register; sel above always sees the pre-write value
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (maskWe) begin
            mask <= maskWd;
        end
    end

    // Vectoring FSM with saved PC and cause; HOLDOFF lets one instruction retire after return
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            epc   <= '0;
            cause <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        epc   <= pcIn;
                        cause <= sel;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (rfe) begin
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INTCTL_EDGE_EN
    logic [NUM_SRC-1:0] irq_prev;

    // Edge capture: rising edges latch until accepted; a new rise on the clear edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irqIn;
            pending  <= (pending & ~clr_vec) | (irqIn & ~irq_prev);
        end
    end
`else
    // Level capture: follows the lines with one cycle latency; the clear lasts one cycle only
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= irqIn & ~clr_vec;
        end
    end
`endif

endmodule

// File: doc/intctl.md
# intctl

Interrupt controller that sources the `irq` and `iaBit` signals consumed by the PC-select logic. It latches peripheral interrupt events, applies a software mask, and raises `irq` toward the fetch stage. It tracks acceptance of the interrupt vector, saves the interrupted PC and cause, and holds `iaBit` high until a return-from-exception completes. It sits beside the PC register in the fetch stage, between the peripherals and the PC-select logic.

## Interface
- `NUM_SRC`, 4: number of interrupt sources, 2..16; index 0 has the highest priority.
- `WIDTH`, 32: PC width.
- `CW`, `$clog2(NUM_SRC)`: cause width; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irqIn`  in  NUM_SRC  peripheral interrupt lines.
- `maskWe`  in  1  mask register write enable.
- `maskWd`  in  NUM_SRC  mask write data; 1 enables the source.
- `illOp`  in  1  illegal-op flag. When set, the exception vector takes precedence over the interrupt.
- `pcEn`  in  1  PC register enable; 0 means fetch is stalled.
- `pcIn`  in  WIDTH  PC to resume at, captured into `epc`.
- `rfe`  in  1  return-from-exception retiring this cycle.
- `irq`  out  1  interrupt request to PC-select.
- `iaBit`  out  1  interrupt active; blocks further vectoring.
- `epc`  out  WIDTH  saved PC.
- `cause`  out  CW  index of the serviced source.
- `pending`  out  NUM_SRC  latched pending events.

## Operation
- Registers reset to 0: `pending`, `mask`, `epc`, `cause`, and the state, which resets to IDLE.
- Outputs after reset: `irq`=0, `iaBit`=0.
- `irq` = |(`pending` & `mask`). It is combinational from registers and is independent of state.
- `iaBit` = 1 in states SERVICE and HOLDOFF.
- Mask: on `maskWe`, `mask` <= `maskWd` at the clock edge.
- Event capture is governed by the configuration macro (see Configuration).
- Select: `sel` = lowest index i with `pending[i] & mask[i]`.
- Acceptance occurs at an edge where all of these hold: state=IDLE, `irq`=1, `illOp`=0, `pcEn`=1. At that edge:
  - `epc` <= `pcIn`
  - `cause` <= `sel`
  - `pending[sel]` cleared
  - state goes to SERVICE
- FSM transitions:
  - IDLE -> SERVICE on acceptance; otherwise stays in IDLE.
  - SERVICE -> HOLDOFF on `rfe`=1; otherwise stays in SERVICE. Interrupts arriving meanwhile stay pending.
  - HOLDOFF -> IDLE unconditionally after one cycle. This guarantees one instruction at the return address executes before the next vector.
- Boundary rules:
  - New event on the same source at its clear edge: set wins, and the bit stays 1.
  - `rfe` in IDLE or HOLDOFF: ignored.
  - `illOp`=1 or `pcEn`=0 in IDLE with `irq`=1: no acceptance, nothing changes, `irq` stays high.
  - Mask cleared while a bit is pending: `irq` drops; the bit stays latched.
  - Mask write coincident with acceptance: `sel` uses the old mask.
  - `reset` in any state: all registers return to reset values at that edge; pending events are discarded.
  - `epc` and `cause` hold their values until the next acceptance.

## Timing
- Event to `irq`: 1 cycle. With `irqIn` rising before edge N, `pending` and `irq` are high after edge N.
- Acceptance to `iaBit`=1: `iaBit` goes high in the cycle after the accepting edge. `epc` and `cause` are valid in that same cycle.
- `rfe` at edge M: `iaBit` stays high through M+1 (HOLDOFF) and is low after edge M+1.
- Minimum spacing between two acceptances: 3 cycles after `rfe`.

## Configuration
- `INTCTL_EDGE_EN` defined (edge mode):
  - `irqIn` is registered to `irqPrev`.
  - `pending[i]` sets at an edge where `irqIn[i]`=1 and `irqPrev[i]`=0.
  - Bits clear only on acceptance.
- `INTCTL_EDGE_EN` undefined (level mode):
  - `pending[i]` is `irqIn[i]` registered each cycle, with 1-cycle latency.
  - The acceptance clear is overridden by the level on the next edge; the peripheral must deassert its line.
  - The set-wins rule does not apply.

## Test plan
- Reset, then pulse `irqIn`=4'b0100 with `mask`=0 -> `pending`=4'b0100, `irq`=0. Write `mask`=4'b1111 -> `irq`=1 the next cycle.
- `mask`=4'hF, `irqIn` rises 4'b1010 at once, `pcEn`=1, `pcIn`=32'h0000_0040 -> accepted the next edge with `cause`=1, `epc`=32'h40, `pending`=4'b1000, `iaBit`=1.
- In IDLE with `irq`=1, hold `illOp`=1 for 3 cycles, then `pcEn`=0 for 2 cycles -> no acceptance, `iaBit`=0. Release both -> accepted on the first edge with both clear.
- In SERVICE, raise source 3 and then `rfe` -> `iaBit` high for exactly one more cycle (HOLDOFF), low for one IDLE cycle, then re-accepted with `cause`=3.
- `rfe` pulsed in IDLE, and `reset` asserted in SERVICE with `pending`=4'b0011 -> the `rfe` changes nothing; after reset all outputs are 0.
- Edge mode: source 0 re-rises on its own clear edge -> `pending[0]` stays 1. Level mode: hold `irqIn[0]` high -> `pending[0]` is 1 again one cycle after the clear.
